// File: rtl/paddle_tracker.sv
// paddle_tracker
//   Keeps the vertical position of NUM_PADDLES fixed-column paddles and moves
//   each one by STEP pixels per frame tick from its own up/down pair. For every
//   paddle that moved (or every paddle when REDRAW_ALL=1) it streams an erase
//   beat at the old position followed by a draw beat at the new position over
//   a valid/ready master port.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   box_init_x [9N-1:0]   static x column per paddle, [9i+8:9i] = paddle i
//   in_color   [3N-1:0]   draw colour per paddle (sampled in CALC)
//   up, down   [N-1:0]    level move requests per paddle (sampled in CALC)
//   m_ready               downstream ready
//   m_valid, box_x, box_y, out_color, out_idx, out_erase   beat port
//   frame_done            one-cycle pulse when a frame has completed
//   overrun               sticky: a tick arrived while one was already pending
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a frame tick (or a pending one)
// CALC  | sample keys/colours, compute next y and moved mask, load beat 0
// EMIT  | stream erase/draw beat pairs for moved paddles, ascending index
// DONE  | one cycle with frame_done high, then back to IDLE

module paddle_tracker #(
    parameter int          NUM_PADDLES      = 2,
    parameter logic [8:0]  BOX_WIDTH        = 9'd10,
    parameter logic [8:0]  BOX_HEIGHT       = 9'd48,
    parameter logic [8:0]  SCREEN_WIDTH     = 9'd320,
    parameter logic [8:0]  SCREEN_HEIGHT    = 9'd240,
    parameter logic [8:0]  STEP             = 9'd4,
    parameter logic [31:0] FRAME_RATE_COUNT = 32'd9999999,
    parameter logic        REDRAW_ALL       = 1'b0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [9*NUM_PADDLES-1:0]   box_init_x,
    input  logic [3*NUM_PADDLES-1:0]   in_color,
    input  logic [NUM_PADDLES-1:0]     up,
    input  logic [NUM_PADDLES-1:0]     down,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [8:0]                 box_x,
    output logic [8:0]                 box_y,
    output logic [2:0]                 out_color,
    output logic [2:0]                 out_idx,
    output logic                       out_erase,
    output logic                       frame_done,
    output logic                       overrun
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;

    localparam logic [8:0] Y_MAX  = SCREEN_HEIGHT - BOX_HEIGHT;
    localparam logic [8:0] Y_INIT = Y_MAX >> 1;

    if (NUM_PADDLES < 1 || NUM_PADDLES > 8 ||
        BOX_HEIGHT > SCREEN_HEIGHT || BOX_WIDTH > SCREEN_WIDTH) begin : g_bad_params
        $error("paddle_tracker: illegal parameter combination");
    end

    state_t      state;
    logic [31:0] frame_cnt;
    logic        tick;
    logic        pending;

    // Per-paddle storage is always 8 deep so a 3-bit index selects it exactly;
    // entries at or above NUM_PADDLES are tied off and never move.
    logic [8:0]  y_q     [8];
    logic [8:0]  ny_q    [8];
    logic [2:0]  col_q   [8];
    logic [7:0]  moved_q;

    logic [8:0]  x_a     [8];
    logic [2:0]  col_a   [8];
    logic [7:0]  up_a;
    logic [7:0]  dn_a;
    logic [8:0]  ny_c    [8];
    logic [7:0]  moved_c;
    logic [3:0]  first_c;
    logic [3:0]  next_c;

    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_PADDLES) begin : g_used
            assign x_a[g]   = box_init_x[9*g +: 9];
            assign col_a[g] = in_color[3*g +: 3];
            assign up_a[g]  = up[g];
            assign dn_a[g]  = down[g];
        end else begin : g_unused
            assign x_a[g]   = '0;
            assign col_a[g] = '0;
            assign up_a[g]  = 1'b0;
            assign dn_a[g]  = 1'b0;
        end
    end

    assign tick = (frame_cnt == FRAME_RATE_COUNT);

    // Lowest set bit of mask at or above start, as {found, index}.
    function automatic logic [3:0] find_from(input logic [7:0] mask, input int start);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && i >= start) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // Saturation is decided by comparing before the add/subtract so the
    // 9-bit arithmetic can never wrap.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ny_c[i]    = y_q[i];
            moved_c[i] = 1'b0;
            if (up_a[i] && !dn_a[i]) begin
                ny_c[i] = (y_q[i] >= STEP) ? y_q[i] - STEP : 9'd0;
            end else if (dn_a[i] && !up_a[i]) begin
                ny_c[i] = (y_q[i] >= Y_MAX - STEP) ? Y_MAX : y_q[i] + STEP;
            end
            if (i < NUM_PADDLES) moved_c[i] = (ny_c[i] != y_q[i]) | REDRAW_ALL;
        end
        first_c = find_from(moved_c, 0);
        next_c  = find_from(moved_q, int'(out_idx) + 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            frame_cnt  <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            m_valid    <= 1'b0;
            box_x      <= '0;
            box_y      <= '0;
            out_color  <= '0;
            out_idx    <= '0;
            out_erase  <= 1'b0;
            frame_done <= 1'b0;
            moved_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                y_q[i]   <= Y_INIT;
                ny_q[i]  <= '0;
                col_q[i] <= '0;
            end
        end else begin
            frame_cnt  <= tick ? 32'd0 : frame_cnt + 32'd1;
            frame_done <= 1'b0;

            if (tick && state != S_IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick || pending) begin
                        state   <= S_CALC;
                        pending <= 1'b0;
                    end
                end

                S_CALC: begin
                    moved_q <= moved_c;
                    for (int i = 0; i < 8; i++) begin
                        ny_q[i]  <= ny_c[i];
                        col_q[i] <= col_a[i];
                    end
                    if (first_c[3]) begin
                        state     <= S_EMIT;
                        m_valid   <= 1'b1;
                        out_idx   <= first_c[2:0];
                        out_erase <= 1'b1;
                        box_x     <= x_a[first_c[2:0]];
                        box_y     <= y_q[first_c[2:0]];
                        out_color <= 3'b000;
                    end else begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end

                S_EMIT: begin
                    if (m_ready) begin
                        if (out_erase) begin
                            out_erase <= 1'b0;
                            box_y     <= ny_q[out_idx];
                            out_color <= col_q[out_idx];
                        end else begin
                            y_q[out_idx] <= ny_q[out_idx];
                            if (next_c[3]) begin
                                out_idx   <= next_c[2:0];
                                out_erase <= 1'b1;
                                box_x     <= x_a[next_c[2:0]];
                                box_y     <= y_q[next_c[2:0]];
                                out_color <= 3'b000;
                            end else begin
                                m_valid    <= 1'b0;
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_tracker.sv
module tb_paddle_tracker;

    typedef struct packed {
        logic [2:0] idx;
        logic       erase;
        logic [8:0] x;
        logic [8:0] y;
        logic [2:0] col;
    } beat_t;

    typedef struct {
        logic [1:0] up;
        logic [1:0] dn;
        int         nfr;
        int         exp_beats;
        int         exp_y0;
        int         exp_y1;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic [17:0] box_init_x;
    logic [5:0]  in_color;
    logic [1:0]  up_r;
    logic [1:0]  dn_r;
    logic        m_ready;

    logic        mv0, er0, fd0s, ov0;
    logic [8:0]  bx0, by0;
    logic [2:0]  col0, idx0;
    logic        mv1, er1, fd1s, ov1;
    logic [8:0]  bx1, by1;
    logic [2:0]  col1, idx1;

    paddle_tracker #(.NUM_PADDLES(2), .FRAME_RATE_COUNT(32'd15), .REDRAW_ALL(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .box_init_x(box_init_x), .in_color(in_color),
        .up(up_r), .down(dn_r), .m_ready(m_ready), .m_valid(mv0), .box_x(bx0), .box_y(by0),
        .out_color(col0), .out_idx(idx0), .out_erase(er0), .frame_done(fd0s), .overrun(ov0)
    );

    paddle_tracker #(.NUM_PADDLES(2), .FRAME_RATE_COUNT(32'd15), .REDRAW_ALL(1'b1)) dut_r (
        .clock(clock), .reset_n(reset_n), .box_init_x(box_init_x), .in_color(in_color),
        .up(up_r), .down(dn_r), .m_ready(m_ready), .m_valid(mv1), .box_x(bx1), .box_y(by1),
        .out_color(col1), .out_idx(idx1), .out_erase(er1), .frame_done(fd1s), .overrun(ov1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    beat_t q0[$];
    beat_t q1[$];
    int    ym[2][2];
    logic [8:0] xs[2] = '{9'd20, 9'd310};
    logic [2:0] cs[2] = '{3'd5, 3'd3};

    int cyc = 0;
    int fd0 = 0, fd1 = 0;
    int fd_last0 = 0, fd_prev0 = 0;
    int rise0 = 0;
    int nb0 = 0;
    int lr_y[8];
    logic mv0_d = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle count since reset release; the frame counter follows it mod 16.
    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) cyc = 0;
        else          cyc++;
    end

    // Scoreboard monitors, sampling on the falling edge.
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (mv0 && m_ready) begin
                beat_t a;
                a = '{idx0, er0, bx0, by0, col0};
                nb0++;
                if (q0.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL beat0_unexpected: got %0h expected none", a);
                end else begin
                    chk("beat0", 32'(a), 32'(q0.pop_front()));
                end
            end
            if (mv1 && m_ready) begin
                beat_t a;
                a = '{idx1, er1, bx1, by1, col1};
                if (!er1) lr_y[idx1] = int'(by1);
                if (q1.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL beat1_unexpected: got %0h expected none", a);
                end else begin
                    chk("beat1", 32'(a), 32'(q1.pop_front()));
                end
            end
            if (fd0s) begin fd_prev0 = fd_last0; fd_last0 = cyc; fd0++; end
            if (fd1s) fd1++;
            if (mv0 && !mv0_d) rise0 = cyc;
        end
        mv0_d = mv0;
    end

    task automatic push_frame(input int inst);
        for (int i = 0; i < 2; i++) begin
            int    oy;
            int    ny;
            beat_t b;
            oy = ym[inst][i];
            ny = oy;
            if (up_r[i] && !dn_r[i])      ny = (oy - 4 < 0) ? 0 : oy - 4;
            else if (dn_r[i] && !up_r[i]) ny = (oy + 4 > 192) ? 192 : oy + 4;
            if (ny != oy || inst == 1) begin
                b = '{3'(i), 1'b1, xs[i], 9'(oy), 3'd0};
                if (inst == 0) q0.push_back(b); else q1.push_back(b);
                b = '{3'(i), 1'b0, xs[i], 9'(ny), cs[i]};
                if (inst == 0) q0.push_back(b); else q1.push_back(b);
            end
            ym[inst][i] = ny;
        end
    endtask

    task automatic wait_frames(input int n);
        int t0, t1, k;
        t0 = fd0 + n;
        t1 = fd1 + n;
        k = 0;
        while ((fd0 < t0 || fd1 < t1) && k < 64 * n + 200) begin
            @(posedge clock); #1;
            k++;
        end
        chk("frame_timeout", 32'(fd0 >= t0 && fd1 >= t1), 32'd1);
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            push_frame(0);
            push_frame(1);
            wait_frames(1);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++)
            for (int i = 0; i < 2; i++) ym[a][i] = 96;
    endtask

    vec_t rows[7];

    initial begin
        int    s;
        int    found;
        int    stable;
        logic [31:0] snap0, snap1;

        rows[0] = '{2'b00, 2'b00,  2,  0, 96,  96};
        rows[1] = '{2'b01, 2'b00,  1,  2, 92,  96};
        rows[2] = '{2'b11, 2'b11,  1,  0, 92,  96};
        rows[3] = '{2'b00, 2'b10, 40, 48, 92, 192};
        rows[4] = '{2'b01, 2'b00, 30, 46,  0, 192};
        rows[5] = '{2'b10, 2'b01,  2,  8,  8, 184};
        rows[6] = '{2'b00, 2'b00,  1,  0,  8, 184};

        m_ready    = 1'b1;
        up_r       = 2'b00;
        dn_r       = 2'b00;
        box_init_x = {xs[1], xs[0]};
        in_color   = {cs[1], cs[0]};
        model_reset();
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("reset_outs0", 32'({mv0, bx0, by0, col0, idx0, er0, fd0s, ov0}), 32'd0);
        chk("reset_outs1", 32'({mv1, bx1, by1, col1, idx1, er1, fd1s, ov1}), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        for (int r = 0; r < 7; r++) begin
            up_r = rows[r].up;
            dn_r = rows[r].dn;
            s = nb0;
            run_frames(rows[r].nfr);
            chk($sformatf("row%0d_beats", r), 32'(nb0 - s), 32'(rows[r].exp_beats));
            chk($sformatf("row%0d_y0", r), 32'(lr_y[0]), 32'(rows[r].exp_y0));
            chk($sformatf("row%0d_y1", r), 32'(lr_y[1]), 32'(rows[r].exp_y1));
            if (r == 0) begin
                chk("frame_period", 32'(fd_last0 - fd_prev0), 32'd16);
                chk("overrun_idle", 32'(ov0), 32'd0);
            end
            if (r == 1) chk("first_valid_latency", 32'(rise0 % 16), 32'd1);
        end

        // Stall a draw beat across two ticks: one frame becomes pending, the
        // next one overruns.
        up_r = 2'b01;
        dn_r = 2'b00;
        push_frame(0); push_frame(1);
        push_frame(0); push_frame(1);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (mv0 && !er0) begin found = 1; break; end
        end
        chk("stall_reach_draw", 32'(found), 32'd1);
        m_ready = 1'b0;
        snap0 = 32'({mv0, idx0, er0, bx0, by0, col0});
        snap1 = 32'({mv1, idx1, er1, bx1, by1, col1});
        stable = 1;
        repeat (50) begin
            @(posedge clock); #1;
            if (32'({mv0, idx0, er0, bx0, by0, col0}) !== snap0) stable = 0;
            if (32'({mv1, idx1, er1, bx1, by1, col1}) !== snap1) stable = 0;
        end
        chk("stall_hold", 32'(stable), 32'd1);
        chk("stall_draw_y", 32'(by0), 32'd4);
        chk("overrun0", 32'(ov0), 32'd1);
        chk("overrun1", 32'(ov1), 32'd1);
        m_ready = 1'b1;
        wait_frames(2);
        chk("stall_y0", 32'(lr_y[0]), 32'd0);

        up_r = 2'b00;
        run_frames(1);

        // Reset in the middle of a frame's beats.
        up_r = 2'b10;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (mv0) begin found = 1; break; end
        end
        chk("rst_reach_emit", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mvalid1", 32'(mv1), 32'd0);
        chk("rst_outs0", 32'({mv0, bx0, by0, col0, idx0, er0, fd0s, ov0}), 32'd0);
        q0.delete();
        q1.delete();
        model_reset();
        up_r = 2'b00;
        dn_r = 2'b10;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        s = nb0;
        run_frames(1);
        dn_r = 2'b00;
        run_frames(1);
        chk("post_rst_beats", 32'(nb0 - s), 32'd2);
        chk("post_rst_y0", 32'(lr_y[0]), 32'd96);
        chk("post_rst_y1", 32'(lr_y[1]), 32'd100);
        chk("queue0_empty", 32'(q0.size()), 32'd0);
        chk("queue1_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
